// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-way intersection controller (NS/EW heads + walk lamp)
// with 1 s prescaler, all-red clearance, latched pedestrian request, flashing mode.
// Latency: lamps/phase/sec_left are registered and change on the clk edge of the
// transition; sec_tick is combinational from the prescaler.
// Backpressure: none; enable=0 freezes prescaler, timer, state and lamps.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   enable     1 = run, 0 = freeze (ped_pending still latches)
//   flash_mode 1 = request maintenance flashing (sampled on sec_tick)
//   ped_req    pedestrian button level, sampled every clk
//   ns_*/ew_*  signal head lamps
//   ped_walk   walk lamp
//   phase      current state encoding (0..7)
//   sec_left   ticks remaining in the current phase minus 1
//   sec_tick   one-clk pulse per second tick
module traffic_light_ctrl #(
  parameter int TICK_DIV = 24000000,
  parameter int GREEN_S  = 30,
  parameter int YELLOW_S = 3,
  parameter int ALLRED_S = 2,
  parameter int PED_S    = 10,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flash_mode,
  input  logic             ped_req,
  output logic             ns_red,
  output logic             ns_yellow,
  output logic             ns_green,
  output logic             ew_red,
  output logic             ew_yellow,
  output logic             ew_green,
  output logic             ped_walk,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] sec_left,
  output logic             sec_tick
);

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_ALL_RED_A = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_ALL_RED_B = 3'd5,
    S_PED_WALK  = 3'd6,
    S_FLASH     = 3'd7
  } state_t;

  typedef struct packed {
    logic ns_r;
    logic ns_y;
    logic ns_g;
    logic ew_r;
    logic ew_y;
    logic ew_g;
    logic walk;
  } lamp_t;

  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PCNT_MAX  = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_S - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_S - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_S - 1);
  localparam logic [CNT_W-1:0] LD_PED    = CNT_W'(PED_S - 1);
  localparam lamp_t            LAMP_RST  = '{ns_r: 1'b1, ew_r: 1'b1, default: 1'b0};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             ped_pending_q, ped_pending_d;
  logic             next_ew_q, next_ew_d;
  logic             flash_y_q, flash_y_d;
  lamp_t            lamps_q, lamps_d;
  logic             tick;

  // Tick only while running, so enable=0 freezes everything downstream.
  assign tick = enable && (pcnt_q == PCNT_MAX);

  // Prescaler
  always_comb begin
    pcnt_d = pcnt_q;
    if (enable) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end
  end

  // Phase sequencing, timer, pedestrian latch and flash toggle
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    next_ew_d     = next_ew_q;
    flash_y_d     = flash_y_q;
    ped_pending_d = ped_pending_q;

    if (tick) begin
      if (flash_mode) begin
        // Flash overrides any pending expiry; yellows start lit on entry.
        state_d   = S_FLASH;
        timer_d   = '0;
        flash_y_d = (state_q == S_FLASH) ? ~flash_y_q : 1'b1;
      end else if (state_q == S_FLASH) begin
        // Leave flash through a clearance interval, then NS gets the green.
        state_d   = S_ALL_RED_B;
        timer_d   = LD_ALLRED;
        next_ew_d = 1'b0;
      end else if (timer_q != '0) begin
        timer_d = timer_q - 1'b1;
      end else begin
        case (state_q)
          S_NS_GREEN: begin
            state_d = S_NS_YELLOW;
            timer_d = LD_YELLOW;
          end
          S_NS_YELLOW: begin
            state_d   = S_ALL_RED_A;
            timer_d   = LD_ALLRED;
            next_ew_d = 1'b1;
          end
          S_ALL_RED_A: begin
            if (ped_pending_q) begin
              state_d = S_PED_WALK;
              timer_d = LD_PED;
            end else begin
              state_d = S_EW_GREEN;
              timer_d = LD_GREEN;
            end
          end
          S_EW_GREEN: begin
            state_d = S_EW_YELLOW;
            timer_d = LD_YELLOW;
          end
          S_EW_YELLOW: begin
            state_d   = S_ALL_RED_B;
            timer_d   = LD_ALLRED;
            next_ew_d = 1'b0;
          end
          S_ALL_RED_B: begin
            if (ped_pending_q) begin
              state_d = S_PED_WALK;
              timer_d = LD_PED;
            end else begin
              state_d = S_NS_GREEN;
              timer_d = LD_GREEN;
            end
          end
          S_PED_WALK: begin
            // Resume with the green that the preceding all-red was heading to.
            state_d = next_ew_q ? S_EW_GREEN : S_NS_GREEN;
            timer_d = LD_GREEN;
          end
          default: begin
            state_d = S_ALL_RED_B;
            timer_d = LD_ALLRED;
          end
        endcase
      end
    end

    // Clear on walk entry beats a simultaneous press; presses during walk are dropped.
    if ((state_d == S_PED_WALK) && (state_q != S_PED_WALK)) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && (state_q != S_PED_WALK)) begin
      ped_pending_d = 1'b1;
    end
  end

  // Lamp decode from the next state so lamps line up with phase.
  always_comb begin
    lamps_d = '0;
    case (state_d)
      S_NS_GREEN: begin
        lamps_d.ns_g = 1'b1;
        lamps_d.ew_r = 1'b1;
      end
      S_NS_YELLOW: begin
        lamps_d.ns_y = 1'b1;
        lamps_d.ew_r = 1'b1;
      end
      S_EW_GREEN: begin
        lamps_d.ew_g = 1'b1;
        lamps_d.ns_r = 1'b1;
      end
      S_EW_YELLOW: begin
        lamps_d.ew_y = 1'b1;
        lamps_d.ns_r = 1'b1;
      end
      S_PED_WALK: begin
        lamps_d.ns_r = 1'b1;
        lamps_d.ew_r = 1'b1;
        lamps_d.walk = 1'b1;
      end
      S_FLASH: begin
        lamps_d.ns_y = flash_y_d;
        lamps_d.ew_y = flash_y_d;
      end
      default: begin
        lamps_d.ns_r = 1'b1;
        lamps_d.ew_r = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_ALL_RED_B;
      timer_q       <= LD_ALLRED;
      pcnt_q        <= '0;
      ped_pending_q <= 1'b0;
      next_ew_q     <= 1'b0;
      flash_y_q     <= 1'b0;
      lamps_q       <= LAMP_RST;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pcnt_q        <= pcnt_d;
      ped_pending_q <= ped_pending_d;
      next_ew_q     <= next_ew_d;
      flash_y_q     <= flash_y_d;
      lamps_q       <= lamps_d;
    end
  end

  assign ns_red    = lamps_q.ns_r;
  assign ns_yellow = lamps_q.ns_y;
  assign ns_green  = lamps_q.ns_g;
  assign ew_red    = lamps_q.ew_r;
  assign ew_yellow = lamps_q.ew_y;
  assign ew_green  = lamps_q.ew_g;
  assign ped_walk  = lamps_q.walk;
  assign phase     = state_q;
  assign sec_left  = timer_q;
  assign sec_tick  = tick;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a tick-level behavioural model.
module tb_traffic_light_ctrl;

  localparam int TD   = 4;
  localparam int G    = 30;
  localparam int Y    = 3;
  localparam int AR   = 2;
  localparam int PEDS = 10;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          reset, enable, flash_mode, ped_req;
  logic          ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk;
  logic [2:0]    phase;
  logic [CW-1:0] sec_left;
  logic          sec_tick;
  logic [6:0]    obs_lamps;

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .TICK_DIV(TD), .GREEN_S(G), .YELLOW_S(Y), .ALLRED_S(AR), .PED_S(PEDS), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .flash_mode(flash_mode), .ped_req(ped_req),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .ped_walk(ped_walk), .phase(phase), .sec_left(sec_left), .sec_tick(sec_tick)
  );

  assign obs_lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (tick level) ----------------
  int m_phase, m_rem, m_pc;      // m_rem: ticks left in phase including the current one
  bit m_ped, m_next_ew, m_y, m_en;
  int walk_entries = 0;
  logic [2:0] prev_phase;

  function automatic int dur(input int p);
    case (p)
      0, 3:    return G;
      1, 4:    return Y;
      2, 5:    return AR;
      6:       return PEDS;
      default: return 1;
    endcase
  endfunction

  function automatic logic [6:0] exp_lamps(input int p, input bit y);
    case (p)
      0:       return 7'b001_100_0;
      1:       return 7'b010_100_0;
      3:       return 7'b100_001_0;
      4:       return 7'b100_010_0;
      6:       return 7'b100_100_1;
      7:       return {1'b0, y, 1'b0, 1'b0, y, 1'b0, 1'b0};
      default: return 7'b100_100_0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 5; m_rem = AR; m_pc = 0;
    m_ped = 0; m_next_ew = 0; m_y = 0; m_en = 0;
  endtask

  task automatic model_edge(input bit pr, input bit en, input bit fm);
    bit tick;
    int nxt;
    tick = en && (m_pc == TD - 1);
    nxt  = m_phase;
    m_en = en;
    if (en) m_pc = (m_pc + 1) % TD;
    if (tick) begin
      if (fm) begin
        m_y = (m_phase == 7) ? !m_y : 1'b1;
        nxt = 7; m_rem = 1;
      end else if (m_phase == 7) begin
        nxt = 5; m_rem = AR; m_next_ew = 0;
      end else if (m_rem > 1) begin
        m_rem--;
      end else begin
        case (m_phase)
          0: nxt = 1;
          1: nxt = 2;
          2: nxt = m_ped ? 6 : 3;
          3: nxt = 4;
          4: nxt = 5;
          5: nxt = m_ped ? 6 : 0;
          default: nxt = m_next_ew ? 3 : 0;
        endcase
        if (nxt == 2) m_next_ew = 1;
        if (nxt == 5) m_next_ew = 0;
        m_rem = dur(nxt);
      end
    end
    if (nxt == 6 && m_phase != 6) m_ped = 0;
    else if (pr && m_phase != 6)  m_ped = 1;
    m_phase = nxt;
  endtask

  task automatic compare(input string where);
    bit viol;
    chk_eq({where, ".phase"},    phase, m_phase);
    chk_eq({where, ".sec_left"}, sec_left, m_rem - 1);
    chk_eq({where, ".lamps"},    obs_lamps, exp_lamps(m_phase, m_y));
    chk_eq({where, ".sec_tick"}, sec_tick, (m_en && m_pc == TD - 1));
    viol = (phase != 3'd7 && (ns_green | ns_yellow) && (ew_green | ew_yellow)) ||
           (ped_walk && !(ns_red && ew_red));
    chk_eq({where, ".safety"}, viol, 1'b0);
    if (phase == 3'd6 && prev_phase != 3'd6) walk_entries++;
    prev_phase = phase;
  endtask

  // Called at posedge+1; inputs change here, away from the active edge.
  task automatic step(input bit pr, input bit en, input bit fm);
    ped_req = pr; enable = en; flash_mode = fm;
    model_edge(pr, en, fm);
    @(posedge clk); #1;
    compare("cyc");
  endtask

  task automatic run_until(input int p, input int max, input bit fm);
    int k;
    k = 0;
    while (phase !== p[2:0] && k < max) begin
      step(1'b0, 1'b1, fm);
      k++;
    end
    chk_eq($sformatf("reach_phase_%0d", p), phase, p);
  endtask

  // Asynchronous reset asserted between edges, held over one edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    model_reset();
    #1 compare("rst_async");
    @(posedge clk); #1;
    compare("rst_hold");
    reset = 1'b1;
  endtask

  int cnt[8];
  bit seen5;
  bit fm_r;

  initial begin
    reset = 1'b0; enable = 1'b0; flash_mode = 1'b0; ped_req = 1'b0;
    prev_phase = 3'd5;
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare("reset");
    reset = 1'b1;

    // Two ticks of clearance after reset, then NS green.
    repeat (8) step(1'b0, 1'b1, 1'b0);
    chk_eq("ns_green_after_8clk", {phase, ns_green}, {3'd0, 1'b1});

    // Full cycle: per-phase dwell in clocks.
    foreach (cnt[i]) cnt[i] = 0;
    cnt[0] = 1; seen5 = 0;
    for (int k = 0; k < 400; k++) begin
      step(1'b0, 1'b1, 1'b0);
      if (phase == 3'd0 && seen5) break;
      cnt[phase]++;
      if (phase == 3'd5) seen5 = 1;
    end
    chk_eq("dwell_ns_green",  cnt[0], G * TD);
    chk_eq("dwell_ns_yellow", cnt[1], Y * TD);
    chk_eq("dwell_allred_a",  cnt[2], AR * TD);
    chk_eq("dwell_ew_green",  cnt[3], G * TD);
    chk_eq("dwell_ew_yellow", cnt[4], Y * TD);
    chk_eq("dwell_allred_b",  cnt[5], AR * TD);

    // Pedestrian pulse in NS green; second pulse inside walk is ignored.
    walk_entries = 0;
    step(1'b1, 1'b1, 1'b0);
    run_until(6, 200, 1'b0);
    chk_eq("walk_lamp", ped_walk, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    run_until(3, 100, 1'b0);
    run_until(0, 300, 1'b0);
    chk_eq("single_walk", walk_entries, 1);

    // Flash mode requested mid EW green.
    run_until(3, 400, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0);
    run_until(7, 10, 1'b1);
    chk_eq("flash_yellows_on", {ns_yellow, ew_yellow}, 2'b11);
    repeat (14) step(1'b0, 1'b1, 1'b1);
    run_until(5, 10, 1'b0);
    run_until(0, 20, 1'b0);

    // Freeze for 20 clocks in NS yellow.
    run_until(1, 300, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    run_until(2, 20, 1'b0);

    // Reset in the middle of a walk.
    step(1'b1, 1'b1, 1'b0);
    run_until(6, 400, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    do_reset();
    chk_eq("rst_walk_off", {ped_walk, phase}, {1'b0, 3'd5});
    repeat (8) step(1'b0, 1'b1, 1'b0);
    chk_eq("no_walk_after_rst", phase, 3'd0);

    // Randomized traffic.
    fm_r = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 299) == 0) fm_r = !fm_r;
      if ($urandom_range(0, 999) == 0) do_reset();
      else step($urandom_range(0, 29) == 0, $urandom_range(0, 15) != 0, fm_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
